// File: rtl/nios_sysid_pkg.sv
// Shared definitions for the Nios sysid checker: FSM states, sysid slave
// word offsets and the retry ceiling.
// Latency: n/a (declarations only). Backpressure: n/a.
package nios_sysid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    WAIT_ID,
    RD_TS,
    WAIT_TS,
    DONE
  } sysid_state_t;

  // Word offsets inside the sysid control slave.
  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  // Extra attempts allowed after a failed first check.
  localparam logic [1:0] MAX_RETRY = 2'd3;

endpackage

// File: rtl/nios_sysid_checker.sv
// Purpose: reads the sysid ID and timestamp words and compares them to the expected build values.
// Latency: done pulses 3 + 2*READ_LATENCY cycles after start is sampled (per attempt 2 + 2*READ_LATENCY).
// Backpressure: none; start is only sampled in IDLE and ignored while busy.
//
// Ports:
//   clock, reset_n          - single clock, asynchronous active-low reset
//   start                   - request a check (sampled in IDLE only)
//   address, read, readdata - master side of the sysid control slave
//   busy                    - high in every state except IDLE
//   done                    - one-cycle pulse when the result is valid
//   id_ok, ts_ok, pass      - compare results, held until the next start
//   id_value, ts_value      - captured register contents
//   retry_cnt               - retries performed (always 0 unless retry is built in)
//
// Build option: define SYSID_CHECK_RETRY_EN to re-run a failed check up to
// MAX_RETRY more times before reporting.
module nios_sysid_checker
  import nios_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID  = 32'd0,
  parameter logic [31:0] EXPECTED_TS  = 32'd1454785888,
  parameter int          READ_LATENCY = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        pass,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [1:0]  retry_cnt
);

  // The wait counter is loaded with READ_LATENCY-1 in the read cycle so that
  // the WAIT state's last cycle is the one where the counter reads zero.
  localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY - 1);
  localparam bit         HAS_WAIT = (READ_LATENCY != 0);

  sysid_state_t state_q, state_d;
  logic [1:0]   lat_cnt_q;
  logic         start_acc;
  logic         cap_id;
  logic         cap_ts;
  logic         retry;

`ifdef SYSID_CHECK_RETRY_EN
  logic         attempt_ok;
`endif

  assign start_acc = (state_q == IDLE) && start;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    read    = 1'b0;
    address = ADDR_ID;
    cap_id  = 1'b0;
    cap_ts  = 1'b0;
    retry   = 1'b0;
`ifdef SYSID_CHECK_RETRY_EN
    // id_value already holds this attempt's ID word when the TS word arrives.
    attempt_ok = (id_value == EXPECTED_ID) && (readdata == EXPECTED_TS);
`endif

    case (state_q)
      IDLE: begin
        if (start) state_d = RD_ID;
      end
      RD_ID: begin
        read    = 1'b1;
        address = ADDR_ID;
        if (HAS_WAIT) begin
          state_d = WAIT_ID;
        end else begin
          cap_id  = 1'b1;
          state_d = RD_TS;
        end
      end
      WAIT_ID: begin
        if (lat_cnt_q == 2'd0) begin
          cap_id  = 1'b1;
          state_d = RD_TS;
        end
      end
      RD_TS: begin
        read    = 1'b1;
        address = ADDR_TS;
        if (HAS_WAIT) state_d = WAIT_TS;
        else          cap_ts  = 1'b1;
      end
      WAIT_TS: begin
        if (lat_cnt_q == 2'd0) cap_ts = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The TS capture closes an attempt: report, or go round again.
    if (cap_ts) begin
      state_d = DONE;
`ifdef SYSID_CHECK_RETRY_EN
      if (!attempt_ok && (retry_cnt != MAX_RETRY)) begin
        state_d = RD_ID;
        retry   = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lat_cnt_q <= 2'd0;
    end else begin
      case (state_q)
        RD_ID, RD_TS:     lat_cnt_q <= LAT_LOAD;
        WAIT_ID, WAIT_TS: lat_cnt_q <= lat_cnt_q - 2'd1;
        default:          lat_cnt_q <= 2'd0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_value <= 32'd0;
      ts_value <= 32'd0;
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      pass     <= 1'b0;
    end else begin
      if (cap_id) id_value <= readdata;
      if (cap_ts) ts_value <= readdata;
      if (cap_ts && (state_d == DONE)) begin
        id_ok <= (id_value == EXPECTED_ID);
        ts_ok <= (readdata == EXPECTED_TS);
        pass  <= (id_value == EXPECTED_ID) && (readdata == EXPECTED_TS);
      end
      // Results read as zero throughout RD_ID of a new check or a retry.
      if (start_acc || retry) begin
        id_value <= 32'd0;
        ts_value <= 32'd0;
        id_ok    <= 1'b0;
        ts_ok    <= 1'b0;
        pass     <= 1'b0;
      end
    end
  end

`ifdef SYSID_CHECK_RETRY_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      retry_cnt <= 2'd0;
    end else if (start_acc) begin
      retry_cnt <= 2'd0;
    end else if (retry) begin
      retry_cnt <= retry_cnt + 2'd1;
    end
  end
`else
  assign retry_cnt = 2'd0;
`endif

endmodule

// File: tb/tb_nios_sysid_checker.sv
// Bench for nios_sysid_checker: one instance with READ_LATENCY=0 and one with
// READ_LATENCY=2, each driven by a sysid slave model whose timestamp word can
// be made wrong for the first N timestamp reads.
module tb_nios_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1454785888;
  localparam logic [31:0] GARB   = 32'hDEAD_BEEF;
`ifdef SYSID_CHECK_RETRY_EN
  localparam int MAX_ATT = 4;
`else
  localparam int MAX_ATT = 1;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        start_s     [2];
  logic        address_s   [2];
  logic        read_s      [2];
  logic [31:0] readdata_s  [2];
  logic        busy_s      [2];
  logic        done_s      [2];
  logic        id_ok_s     [2];
  logic        ts_ok_s     [2];
  logic        pass_s      [2];
  logic [31:0] id_value_s  [2];
  logic [31:0] ts_value_s  [2];
  logic [1:0]  retry_cnt_s [2];

  nios_sysid_checker #(.READ_LATENCY(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .start(start_s[0]),
    .address(address_s[0]), .read(read_s[0]), .readdata(readdata_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .id_ok(id_ok_s[0]), .ts_ok(ts_ok_s[0]),
    .pass(pass_s[0]), .id_value(id_value_s[0]), .ts_value(ts_value_s[0]),
    .retry_cnt(retry_cnt_s[0]));

  nios_sysid_checker #(.READ_LATENCY(2)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start_s[1]),
    .address(address_s[1]), .read(read_s[1]), .readdata(readdata_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .id_ok(id_ok_s[1]), .ts_ok(ts_ok_s[1]),
    .pass(pass_s[1]), .id_value(id_value_s[1]), .ts_value(ts_value_s[1]),
    .retry_cnt(retry_cnt_s[1]));

  // Slave model configuration: ID word, good/bad TS word, number of bad TS
  // reads counted from ts_base.
  logic [31:0] sl_id [2];
  logic [31:0] sl_good [2];
  logic [31:0] sl_bad [2];
  int          sl_nbad [2];
  int          ts_base [2];
  int          ts_cnt [2];
  logic [31:0] pipe_a, pipe_b;

  initial begin
    ts_cnt[0] = 0;
    ts_cnt[1] = 0;
  end

  always @(posedge clock) begin
    for (int d = 0; d < 2; d++)
      if (read_s[d] && address_s[d]) ts_cnt[d] <= ts_cnt[d] + 1;
  end

  // Zero-latency slave answers in the strobe cycle; garbage otherwise.
  assign readdata_s[0] = !read_s[0] ? GARB :
                         address_s[0] ? (((ts_cnt[0] - ts_base[0]) < sl_nbad[0]) ? sl_bad[0] : sl_good[0])
                                      : sl_id[0];

  // Two-cycle slave: data valid exactly two cycles after the strobe.
  always @(posedge clock) begin
    pipe_a <= !read_s[1] ? GARB :
              address_s[1] ? (((ts_cnt[1] - ts_base[1]) < sl_nbad[1]) ? sl_bad[1] : sl_good[1])
                           : sl_id[1];
    pipe_b <= pipe_a;
  end
  assign readdata_s[1] = pipe_b;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs one check on DUT d, starting in the current (negedge) cycle = cycle 0,
  // and compares everything against the attempt-by-attempt model.
  task automatic run_txn(input int d, input logic [31:0] idr, input logic [31:0] good,
                         input logic [31:0] bad, input int nbad, input string tag);
    int lat, per, n_att, cyc, got_done, sig_a, sig_e;
    bit ok, busy_bad;
    logic [31:0] tsv;
    int exp_q[$];
    int act_q[$];
    lat = (d == 0) ? 0 : 2;
    per = 2 + 2 * lat;
    n_att = 0;
    ok = 1'b0;
    tsv = good;
    while (!ok && n_att < MAX_ATT) begin
      tsv = (n_att < nbad) ? bad : good;
      ok = (idr == EXP_ID) && (tsv == EXP_TS);
      exp_q.push_back((1 + n_att * per) * 2);
      exp_q.push_back((2 + lat + n_att * per) * 2 + 1);
      n_att++;
    end
    sl_id[d] = idr; sl_good[d] = good; sl_bad[d] = bad; sl_nbad[d] = nbad;
    ts_base[d] = ts_cnt[d];
    start_s[d] = 1'b1;
    @(negedge clock);
    start_s[d] = 1'b0;
    cyc = 1;
    check({tag, " clr id_value"}, id_value_s[d], 32'd0);
    check({tag, " clr pass"}, {31'd0, pass_s[d]}, 32'd0);
    got_done = -1;
    busy_bad = 1'b0;
    while (cyc <= 60) begin
      if (read_s[d]) act_q.push_back(cyc * 2 + int'(address_s[d]));
      if (!busy_s[d]) busy_bad = 1'b1;
      if (done_s[d]) begin
        got_done = cyc;
        break;
      end
      @(negedge clock);
      cyc++;
    end
    sig_a = 0;
    sig_e = 0;
    foreach (act_q[i]) sig_a += act_q[i] * (i + 1);
    foreach (exp_q[i]) sig_e += exp_q[i] * (i + 1);
    check({tag, " done cycle"}, got_done, 1 + n_att * per);
    check({tag, " read count"}, act_q.size(), exp_q.size());
    check({tag, " read slots"}, sig_a, sig_e);
    check({tag, " busy"}, {31'd0, busy_bad}, 32'd0);
    check({tag, " id_ok"}, {31'd0, id_ok_s[d]}, {31'd0, idr == EXP_ID});
    check({tag, " ts_ok"}, {31'd0, ts_ok_s[d]}, {31'd0, tsv == EXP_TS});
    check({tag, " pass"}, {31'd0, pass_s[d]}, {31'd0, ok});
    check({tag, " id_value"}, id_value_s[d], idr);
    check({tag, " ts_value"}, ts_value_s[d], tsv);
    check({tag, " retry_cnt"}, {30'd0, retry_cnt_s[d]}, n_att - 1);
    @(negedge clock);
    check({tag, " done width"}, {31'd0, done_s[d]}, 32'd0);
    check({tag, " idle after"}, {31'd0, busy_s[d]}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] id;
    logic [31:0] ts;
    logic        e_id_ok;
    logic        e_ts_ok;
    logic        e_pass;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int dones, reads, dsig;
    tbl[0] = '{EXP_ID,        EXP_TS,                 1'b1, 1'b1, 1'b1};
    tbl[1] = '{EXP_ID,        32'h0000_0001,          1'b1, 1'b0, 1'b0};
    tbl[2] = '{32'd1,         EXP_TS,                 1'b0, 1'b1, 1'b0};
    tbl[3] = '{32'h8000_0000, EXP_TS ^ 32'd1,         1'b0, 1'b0, 1'b0};
    tbl[4] = '{EXP_ID,        EXP_TS ^ 32'h8000_0000, 1'b1, 1'b0, 1'b0};

    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0;
      sl_id[d] = EXP_ID; sl_good[d] = EXP_TS; sl_bad[d] = EXP_TS; sl_nbad[d] = 0;
      ts_base[d] = 0;
    end
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst busy", {31'd0, busy_s[d]}, 32'd0);
      check("rst done", {31'd0, done_s[d]}, 32'd0);
      check("rst read", {31'd0, read_s[d]}, 32'd0);
      check("rst address", {31'd0, address_s[d]}, 32'd0);
      check("rst pass", {29'd0, id_ok_s[d], ts_ok_s[d], pass_s[d]}, 32'd0);
      check("rst values", id_value_s[d] | ts_value_s[d], 32'd0);
      check("rst retry_cnt", {30'd0, retry_cnt_s[d]}, 32'd0);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Table vectors on both latencies; run_txn leaves us in the cycle after
    // DONE, so consecutive entries also exercise back-to-back starts.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 5; i++) begin
        run_txn(d, tbl[i].id, tbl[i].ts, tbl[i].ts, 0, $sformatf("tbl%0d/d%0d", i, d));
        check("tbl id_ok", {31'd0, id_ok_s[d]}, {31'd0, tbl[i].e_id_ok});
        check("tbl ts_ok", {31'd0, ts_ok_s[d]}, {31'd0, tbl[i].e_ts_ok});
        check("tbl pass", {31'd0, pass_s[d]}, {31'd0, tbl[i].e_pass});
      end
    end

    // Timestamp wrong for the first two reads only.
    run_txn(0, EXP_ID, EXP_TS, 32'h0000_0001, 2, "late pass d0");
    run_txn(1, EXP_ID, EXP_TS, 32'h0000_0001, 2, "late pass d1");

    // Reset while the latency-2 instance sits in WAIT_TS (cycle 5).
    start_s[1] = 1'b1;
    @(negedge clock);
    start_s[1] = 1'b0;
    repeat (4) @(negedge clock);
    check("pre-reset busy", {31'd0, busy_s[1]}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid reset busy", {31'd0, busy_s[1]}, 32'd0);
    check("mid reset read", {31'd0, read_s[1]}, 32'd0);
    check("mid reset id_value", id_value_s[1], 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(negedge clock);
      if (done_s[0] || done_s[1]) dones++;
    end
    check("no done after reset", dones, 0);
    run_txn(1, EXP_ID, EXP_TS, EXP_TS, 0, "after reset");

    // start held high for cycles 0..11 on the zero-latency instance:
    // sequences start at 0, 4, 8 and finish at 3, 7, 11.
    sl_id[0] = EXP_ID; sl_good[0] = EXP_TS; sl_nbad[0] = 0;
    start_s[0] = 1'b1;
    dones = 0; reads = 0; dsig = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (c == 12) start_s[0] = 1'b0;
      if (read_s[0]) reads++;
      if (done_s[0]) begin
        dones++;
        dsig += c;
      end
    end
    check("held start dones", dones, 3);
    check("held start done cycles", dsig, 3 + 7 + 11);
    check("held start reads", reads, 6);

    // Randomized checks against the model.
    for (int k = 0; k < 12; k++) begin
      int d;
      logic [31:0] idr, good, bad;
      d    = int'($urandom_range(0, 1));
      idr  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : EXP_ID;
      good = ($urandom_range(0, 3) == 0) ? (EXP_TS ^ (32'd1 << $urandom_range(0, 31))) : EXP_TS;
      bad  = 32'($urandom);
      run_txn(d, idr, good, bad, int'($urandom_range(0, 5)), $sformatf("rnd%0d/d%0d", k, d));
      if ($urandom_range(0, 1) == 1) @(negedge clock);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nios_sysid_checker.md
NIOS_SYSID_CHECKER -- requirements
Module: nios_sysid_checker

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'd0, which is the value expected at sysid offset 0 (ID register).
REQ-002 SHALL have parameter EXPECTED_TS, default 32'd1454785888, which is the value expected at sysid offset 1 (timestamp).
REQ-003 SHALL have parameter READ_LATENCY, default 0, legal range 0..3: the number of cycles from the read strobe to valid readdata.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: request a check; sampled only in IDLE.
REQ-007 SHALL have port address, output, 1 bit: word address to the sysid control slave.
REQ-008 SHALL have port read, output, 1 bit: read strobe to the sysid slave.
REQ-009 SHALL have port readdata, input, 32 bits: data returned by the sysid slave.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-012 SHALL have ports id_ok and ts_ok, outputs, 1 bit each: per-register compare results.
REQ-013 SHALL have port pass, output, 1 bit: equal to id_ok AND ts_ok.
REQ-014 SHALL have ports id_value and ts_value, outputs, 32 bits each: captured register contents.
REQ-015 SHALL have port retry_cnt, output, 2 bits: number of retries performed.

Function
REQ-016 SHALL implement FSM states IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, DONE.
REQ-017 SHALL go IDLE->RD_ID on start=1; start is ignored in all other states.
REQ-018 RD_ID SHALL drive read=1, address=0 for exactly one cycle; RD_TS SHALL drive read=1, address=1 for exactly one cycle; read=0 and address=0 elsewhere.
REQ-019 WAIT_x SHALL last READ_LATENCY cycles, counted by a 2-bit down-counter; with READ_LATENCY=0, WAIT_x SHALL be skipped.
REQ-020 readdata SHALL be captured into id_value/ts_value at the end of the last WAIT_x cycle, or at the end of the RD_x cycle if READ_LATENCY=0.
REQ-021 Compares SHALL be full 32-bit equality; id_ok, ts_ok and pass SHALL be registered on entry to DONE.
REQ-022 With start sampled in cycle 0, done SHALL assert in cycle 3+2*READ_LATENCY, for one cycle, then the FSM SHALL return to IDLE.
REQ-023 id_ok, ts_ok, pass, id_value and ts_value SHALL hold until the next start is accepted, then clear to 0 in RD_ID.
REQ-024 Back-to-back: start=1 in the cycle after DONE SHALL be accepted.

Reset
REQ-025 reset_n=0 SHALL immediately force IDLE and set all outputs and counters to 0, including mid-operation; no done pulse SHALL follow reset.
REQ-026 After reset release, the first start SHALL run a full sequence.

Configuration
REQ-027 With SYSID_CHECK_RETRY_EN defined, on pass=0 after the TS capture the FSM SHALL return to RD_ID, up to 3 retries, incrementing retry_cnt; done SHALL fire only on pass or after the third failed retry.
REQ-028 Without SYSID_CHECK_RETRY_EN, there SHALL be one attempt only and retry_cnt SHALL be tied to 0.

Structure
REQ-029 The FSM state enum, the register offsets (ID=0, TS=1) and MAX_RETRY=3 SHALL live in shared package nios_sysid_pkg.
REQ-030 The design SHALL be a single module with no sub-modules; the latency counter is inline.

Verification
REQ-031 READ_LATENCY=0, slave model returning 0/1454785888, start pulse -> read at address 0 in cycle 1, address 1 in cycle 2, done in cycle 3, pass=1.
REQ-032 READ_LATENCY=2, same data -> done in cycle 7, id_value=0, ts_value=1454785888.
REQ-033 Timestamp returns 32'h0000_0001 -> ts_ok=0, id_ok=1, pass=0; with retry enabled, done after 4 attempts with retry_cnt=3.
REQ-034 reset_n=0 asserted in WAIT_TS -> busy=0 and read=0 immediately, no done; a new start then passes.
REQ-035 start held high continuously -> sequences run back-to-back; start pulses while busy cause no extra reads.
